// File: rtl/fdiv_scheduler_if.sv
// Requester and response channels of the divider scheduler: N packed request ports in,
// one valid/ready result port out.
interface fdiv_scheduler_if #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = 1
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [2*N-1:0]  req_rm;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [31:0]     resp_s;

    modport master (
        output req_valid, req_a, req_b, req_rm, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_s
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rm, resp_ready,
        output req_ready, resp_valid, resp_id, resp_s
    );
endinterface

// File: rtl/fdiv_scheduler.sv
// Round-robin front end for one shared iterative float divider: a single operation in flight,
// its quotient parked in a response register until the consumer takes it.
module fdiv_scheduler #(
    parameter int unsigned N       = 2,
    parameter int unsigned IDW     = 1,
    parameter int unsigned RES_DLY = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic            clk,
    input  logic            rst,
    fdiv_scheduler_if.slave bus,
    input  logic            flush,
    output logic [31:0]     div_a,
    output logic [31:0]     div_b,
    output logic [1:0]      div_rm,
    output logic            div_fdiv,
    output logic            div_ena,
    input  logic            div_busy,
    input  logic [31:0]     div_s,
    output logic            ctl_busy,
    output logic            err
);
    localparam int unsigned CntMax = (TIMEOUT > RES_DLY) ? TIMEOUT : RES_DLY;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StBusy, StDrain, StResp} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     resp_s_q, resp_s_d;
    logic [1:0]      rm_q, rm_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            kill_q, kill_d;
    logic            err_q, err_d;
    logic            ena_q, ena_d;

    logic            grant_vld;
    logic            grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    // Walk from the pointer downwards in priority so the closest valid index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_q) + k) % int'(N));
            if (bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // div_busy guard: after a reset mid-operation the divider may still be finishing.
    assign grant = grant_vld & ~flush & ~div_busy & ~rst;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        id_d          = id_q;
        resp_id_d     = resp_id_q;
        a_d           = a_q;
        b_d           = b_q;
        rm_d          = rm_q;
        resp_s_d      = resp_s_q;
        cnt_d         = cnt_q;
        kill_d        = kill_q;
        err_d         = err_q;
        ena_d         = 1'b1;
        bus.req_ready = '0;
        div_fdiv      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    a_d     = bus.req_a[32*int'(grant_idx) +: 32];
                    b_d     = bus.req_b[32*int'(grant_idx) +: 32];
                    rm_d    = bus.req_rm[2*int'(grant_idx) +: 2];
                    id_d    = grant_idx;
                    rr_d    = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
                    kill_d  = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                div_fdiv = 1'b1;
                cnt_d    = '0;
                if (flush) kill_d = 1'b1;
                state_d  = StBusy;
            end
            StBusy: begin
                if (flush) kill_d = 1'b1;
                if (!div_busy) begin
                    cnt_d   = CntW'(RES_DLY - 1);
                    state_d = StDrain;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    kill_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    resp_s_d  = div_s;
                    resp_id_d = id_q;
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StResp;
                    end
                end else begin
                    if (flush) kill_d = 1'b1;
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (bus.resp_ready || flush) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            id_q      <= '0;
            resp_id_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= '0;
            resp_s_q  <= '0;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            err_q     <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            resp_id_q <= resp_id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rm_q      <= rm_d;
            resp_s_q  <= resp_s_d;
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
            err_q     <= err_d;
            ena_q     <= ena_d;
        end
    end

    assign div_a          = a_q;
    assign div_b          = b_q;
    assign div_rm         = rm_q;
    assign div_ena        = ena_q;
    assign ctl_busy       = (state_q != StIdle);
    assign err            = err_q;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_s     = resp_s_q;
    assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_fdiv_scheduler.sv
// Directed bench for fdiv_scheduler with a behavioural divider: busy for busy_len cycles,
// quotient from a small lookup table RES_DLY cycles after busy falls.
module tb_fdiv_scheduler;
    localparam int unsigned N       = 2;
    localparam int unsigned IDW     = 1;
    localparam int unsigned RES_DLY = 4;
    localparam int unsigned TIMEOUT = 31;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        flush    = 1'b0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [1:0]  div_rm;
    logic        div_fdiv;
    logic        div_ena;
    logic        div_busy = 1'b0;
    logic [31:0] div_s    = 32'hDEADBEEF;
    logic        ctl_busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    int          busy_len  = 3;
    bit          hang      = 1'b0;
    int          busy_left = 0;
    int          dly       = 0;
    logic [31:0] m_res     = '0;
    int          fdiv_cnt  = 0;

    fdiv_scheduler_if #(.N(N), .IDW(IDW)) bus ();

    fdiv_scheduler #(
        .N       (N),
        .IDW     (IDW),
        .RES_DLY (RES_DLY),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_rm   (div_rm),
        .div_fdiv (div_fdiv),
        .div_ena  (div_ena),
        .div_busy (div_busy),
        .div_s    (div_s),
        .ctl_busy (ctl_busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40000000}: return 32'h40400000;  // 6 / 2
            {32'h3F800000, 32'h40800000}: return 32'h3E800000;  // 1 / 4
            {32'h41200000, 32'h40A00000}: return 32'h40000000;  // 10 / 5
            {32'h3F800000, 32'h40000000}: return 32'h3F000000;  // 1 / 2
            default:                      return 32'hBAD0BAD0;
        endcase
    endfunction

    // Divider model; it ignores rst, like a real unit finishing its current iteration.
    always @(posedge clk) begin
        if (div_fdiv) begin
            m_res     <= quot(div_a, div_b);
            busy_left <= busy_len;
            div_busy  <= 1'b1;
            dly       <= 0;
            div_s     <= 32'hDEADBEEF;
        end else if (div_busy) begin
            if (busy_left > 1) busy_left <= busy_left - 1;
            else if (!hang) begin
                div_busy <= 1'b0;
                dly      <= RES_DLY;
            end
        end else if (dly != 0) begin
            if (dly == 1) div_s <= m_res;
            dly <= dly - 1;
        end
        if (div_fdiv) fdiv_cnt <= fdiv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_rm[2*i +: 2]  = rm;
    endtask

    task automatic wait_resp(input int limit, output int cyc);
        cyc = 0;
        while (!bus.resp_valid && cyc < limit) begin
            tick();
            cyc++;
        end
        check("resp_arrives", {31'b0, bus.resp_valid}, 32'd1);
    endtask

    task automatic finish_op(output logic [31:0] s, output logic [IDW-1:0] id);
        int c;
        wait_resp(100, c);
        s  = bus.resp_s;
        id = bus.resp_id;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          f0;
        int          cyc;
        bit          stable;
        bit          st_v, st_s, st_id, st_rdy;
        bit          saw_resp, saw_ready;
        logic [31:0] s;
        logic [IDW-1:0] id;
        int          grants[4];
        int          ids[4];
        logic [31:0] res[4];
        int          ng, nr, guard;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_rm     = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ena", {31'b0, div_ena}, 32'd0);
        check("rst_ctl_busy", {31'b0, ctl_busy}, 32'd0);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        tick();
        check("ena_after_rst", {31'b0, div_ena}, 32'd1);

        // Normal divide 6/2 on requester 0
        set_req(0, 32'h40C00000, 32'h40000000, 2'd0);
        bus.req_valid = 2'b01;
        #1;
        check("t1_grant", {30'b0, bus.req_ready}, 32'd1);
        f0 = fdiv_cnt;
        tick();
        bus.req_valid = 2'b00;
        check("t1_fdiv", {31'b0, div_fdiv}, 32'd1);
        stable = 1'b1;
        lat    = 1;
        while (!bus.resp_valid && lat < 100) begin
            stable &= (div_a == 32'h40C00000) && (div_b == 32'h40000000) && (div_rm == 2'd0);
            tick();
            lat++;
        end
        check("t1_operands_stable", {31'b0, stable}, 32'd1);
        check("t1_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        check("t1_resp_s", bus.resp_s, 32'h40400000);
        check("t1_resp_id", {31'b0, bus.resp_id}, 32'd0);
        // Busy is observed high for busy_len cycles plus one BUSY cycle to see it fall.
        check("t1_latency", lat, 3 + busy_len + RES_DLY);
        check("t1_fdiv_once", fdiv_cnt - f0, 32'd1);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("t1_resp_drop", {31'b0, bus.resp_valid}, 32'd0);
        check("t1_idle", {31'b0, ctl_busy}, 32'd0);

        // Round robin with both requesters always valid
        do_reset();
        set_req(0, 32'h41200000, 32'h40A00000, 2'd1);
        set_req(1, 32'h3F800000, 32'h40800000, 2'd2);
        for (int i = 0; i < 4; i++) grants[i] = 9;
        for (int i = 0; i < 4; i++) ids[i] = 9;
        ng = 0;
        nr = 0;
        guard = 0;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 1'b1;
        #1;
        while (nr < 4 && guard < 200) begin
            if (bus.req_ready != 2'b00 && ng < 4) begin
                grants[ng] = (bus.req_ready == 2'b01) ? 0 : ((bus.req_ready == 2'b10) ? 1 : 9);
                ng++;
            end
            if (bus.resp_valid) begin
                ids[nr] = int'(bus.resp_id);
                res[nr] = bus.resp_s;
                nr++;
            end
            if (nr == 4) bus.req_valid = 2'b00;
            tick();
            guard++;
        end
        bus.resp_ready = 1'b0;
        check("rr_resp_count", nr, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i), grants[i], i % 2);
            check($sformatf("rr_id%0d", i), ids[i], i % 2);
            check($sformatf("rr_quot%0d", i), res[i], (i % 2 == 1) ? 32'h3E800000 : 32'h40000000);
        end

        // Backpressure: result held for 10 cycles, regrant one cycle after handshake
        set_req(0, 32'h40C00000, 32'h40000000, 2'd3);
        bus.req_valid = 2'b01;
        #1;
        check("bp_grant", {30'b0, bus.req_ready}, 32'd1);
        tick();
        check("bp_issue_rm", {30'b0, div_rm}, 32'd3);
        wait_resp(100, cyc);
        st_v = 1'b1;
        st_s = 1'b1;
        st_id = 1'b1;
        st_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            st_v   &= bus.resp_valid;
            st_s   &= (bus.resp_s == 32'h40400000);
            st_id  &= (bus.resp_id == 1'b0);
            st_rdy &= (bus.req_ready == 2'b00);
            tick();
        end
        check("bp_valid_held", {31'b0, st_v}, 32'd1);
        check("bp_s_held", {31'b0, st_s}, 32'd1);
        check("bp_id_held", {31'b0, st_id}, 32'd1);
        check("bp_no_ready", {31'b0, st_rdy}, 32'd1);
        bus.resp_ready = 1'b1;
        #1;
        check("bp_hs_no_ready", {30'b0, bus.req_ready}, 32'd0);
        tick();
        bus.resp_ready = 1'b0;
        check("bp_next_grant", {30'b0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        finish_op(s, id);
        check("bp_second_quot", s, 32'h40400000);

        // Flush during BUSY: no response, pending requester 1 served afterwards
        busy_len = 6;
        set_req(1, 32'h3F800000, 32'h40000000, 2'd0);
        bus.req_valid = 2'b01;
        #1;
        check("fl_grant0", {30'b0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b10;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cyc = 3;
        saw_resp = 1'b0;
        saw_ready = 1'b0;
        while (ctl_busy && cyc < 60) begin
            saw_resp  |= bus.resp_valid;
            saw_ready |= (bus.req_ready != 2'b00);
            tick();
            cyc++;
        end
        check("fl_no_resp", {31'b0, saw_resp}, 32'd0);
        check("fl_no_ready_while_busy", {31'b0, saw_ready}, 32'd0);
        check("fl_busy_fall", cyc, 3 + busy_len + RES_DLY);
        check("fl_req1_grant", {30'b0, bus.req_ready}, 32'd2);
        tick();
        bus.req_valid = 2'b00;
        finish_op(s, id);
        check("fl_req1_quot", s, 32'h3F000000);
        check("fl_req1_id", {31'b0, id}, 32'd1);

        // Timeout: divider never drops busy
        busy_len = 3;
        hang = 1'b1;
        bus.req_valid = 2'b01;
        #1;
        check("to_grant", {30'b0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        for (int i = 1; i < 32; i++) tick();
        check("to_err_early", {31'b0, err}, 32'd0);
        check("to_still_busy", {31'b0, ctl_busy}, 32'd1);
        tick();
        check("to_err_set", {31'b0, err}, 32'd1);
        check("to_idle", {31'b0, ctl_busy}, 32'd0);
        bus.req_valid = 2'b01;
        st_v = 1'b1;
        st_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            st_v   &= err & ~ctl_busy & ~bus.resp_valid;
            st_rdy &= (bus.req_ready == 2'b00);
            tick();
        end
        bus.req_valid = 2'b00;
        check("to_err_sticky", {31'b0, st_v}, 32'd1);
        check("to_busy_blocks_grant", {31'b0, st_rdy}, 32'd1);

        // Reset mid-operation while the divider stays busy for 5 more cycles
        hang = 1'b0;
        tick();
        tick();
        do_reset();
        check("rst_err_clear", {31'b0, err}, 32'd0);
        busy_len = 7;
        bus.req_valid = 2'b01;
        #1;
        check("rm_grant", {30'b0, bus.req_ready}, 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_ctl_busy", {31'b0, ctl_busy}, 32'd0);
        check("rm_ready", {30'b0, bus.req_ready}, 32'd0);
        check("rm_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rm_resp_s", bus.resp_s, 32'd0);
        check("rm_resp_id", {31'b0, bus.resp_id}, 32'd0);
        check("rm_div_a", div_a, 32'd0);
        check("rm_div_b", div_b, 32'd0);
        check("rm_div_rm", {30'b0, div_rm}, 32'd0);
        check("rm_fdiv", {31'b0, div_fdiv}, 32'd0);
        check("rm_ena", {31'b0, div_ena}, 32'd0);
        check("rm_err", {31'b0, err}, 32'd0);
        st_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            st_rdy &= (bus.req_ready == 2'b00);
            tick();
        end
        check("rm_no_grant_while_busy", {31'b0, st_rdy}, 32'd1);
        check("rm_grant_after_busy", {30'b0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        finish_op(s, id);
        check("rm_quot", s, 32'h40400000);

        // Flush while the response is waiting
        bus.req_valid = 2'b01;
        #1;
        tick();
        bus.req_valid = 2'b00;
        wait_resp(100, cyc);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("rf_valid_drop", {31'b0, bus.resp_valid}, 32'd0);
        check("rf_idle", {31'b0, ctl_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
